// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM for the MultiplyCPU datapath: sequences IF/ID/EXE/MEM/WB
// and decodes op/zero into every datapath enable and select.
module multi_cycle_control (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [3:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic [1:0] PCSrc
);
    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_AL = 4'b0010,
        S_WB_AL  = 4'b0011,
        S_EXE_BR = 4'b0100,
        S_EXE_LS = 4'b0101,
        S_MEM    = 4'b0110,
        S_WB_LD  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t cur, nxt;

    assign state = cur;

    always_ff @(posedge CLK) begin
        if (Reset) cur <= S_IF;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IF: nxt = S_ID;
            S_ID: begin
                case (op)
                    OP_J, OP_JR, OP_JAL: nxt = S_IF;
                    OP_HALT:             nxt = S_HALT;
                    OP_BEQ:              nxt = S_EXE_BR;
                    OP_LW, OP_SW:        nxt = S_EXE_LS;
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT:
                                         nxt = S_EXE_AL;
                    default:             nxt = S_IF;
                endcase
            end
            S_EXE_AL: nxt = S_WB_AL;
            S_WB_AL:  nxt = S_IF;
            S_EXE_BR: nxt = S_IF;
            S_EXE_LS: nxt = S_MEM;
            S_MEM:    nxt = (op == OP_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  nxt = S_IF;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_IF;
        endcase
    end

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        InsMemRW  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b0;
        DBDataSrc = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        PCSrc     = 2'b00;

        // op is only meaningful after IF, so selects stay at 0 in IF and HALT
        if (cur != S_IF && cur != S_HALT) begin
            ExtSel    = 1'b1;
            WrRegDSrc = 1'b1;
            case (op)
                OP_ADD:  RegDst = 2'b10;
                OP_SUB:  begin RegDst = 2'b10; ALUOp = 3'b001; end
                OP_ADDI: begin RegDst = 2'b01; ALUSrcB = 1'b1; end
                OP_OR:   begin RegDst = 2'b10; ALUOp = 3'b011; end
                OP_AND:  begin RegDst = 2'b10; ALUOp = 3'b100; end
                OP_ORI:  begin RegDst = 2'b01; ALUSrcB = 1'b1; ALUOp = 3'b011; ExtSel = 1'b0; end
                OP_SLL:  begin RegDst = 2'b10; ALUSrcA = 1'b1; ALUOp = 3'b010; end
                OP_SLT:  begin RegDst = 2'b10; ALUOp = 3'b101; end
                OP_SW:   ALUSrcB = 1'b1;
                OP_LW:   begin RegDst = 2'b01; ALUSrcB = 1'b1; DBDataSrc = 1'b1; end
                OP_BEQ:  begin ALUOp = 3'b001; PCSrc = zero ? 2'b01 : 2'b00; end
                OP_J:    PCSrc = 2'b11;
                OP_JR:   PCSrc = 2'b10;
                OP_JAL:  begin PCSrc = 2'b11; WrRegDSrc = 1'b0; end
                default: begin ExtSel = 1'b0; WrRegDSrc = 1'b0; end
            endcase
        end

        case (cur)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                case (op)
                    OP_J, OP_JR: PCWre = 1'b1;
                    OP_JAL:      begin PCWre = 1'b1; RegWre = 1'b1; end
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT,
                    OP_SW, OP_LW, OP_BEQ, OP_HALT: ;
                    default:     PCWre = 1'b1;
                endcase
            end
            S_EXE_BR: PCWre = 1'b1;
            S_MEM: begin
                if (op == OP_SW) begin
                    PCWre = 1'b1;
                    mWR   = 1'b1;
                end
                if (op == OP_LW) mRD = 1'b1;
            end
            S_WB_AL: begin PCWre = 1'b1; RegWre = 1'b1; end
            S_WB_LD: begin PCWre = 1'b1; RegWre = 1'b1; mRD = 1'b1; end
            default: ;
        endcase

        // Reset suppresses every write/load strobe in the cycle it is sampled
        if (Reset) begin
            PCWre  = 1'b0;
            IRWre  = 1'b0;
            RegWre = 1'b0;
            mRD    = 1'b0;
            mWR    = 1'b0;
        end
    end
endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
Multi-cycle control unit FSM for the MultiplyCPU datapath. It sits directly downstream of InstructionMemory: it consumes the decoded op field and the ALU zero flag. It sequences each instruction through IF/ID/EXE/MEM/WB. Each cycle it drives IRWre, InsMemRW and every datapath enable/select (PC, register file, ALU, data memory).

Parameters:
none (opcode and state encodings are fixed below)

Ports:
CLK  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; state -> IF on the next CLK edge
op  input  6  opcode from InstructionMemory; stable from the cycle after IF until the next IF
zero  input  1  ALU zero flag, valid in EXE_BR
state  output  4  current state, for debug/bench
PCWre  output  1  PC register write enable
IRWre  output  1  instruction register load; drives InstructionMemory.IRWre
InsMemRW  output  1  instruction memory read/write; constant 0 (read)
RegWre  output  1  register file write enable
ALUSrcA  output  1  0 = rs data, 1 = zero-extended sa (sll only)
ALUSrcB  output  1  0 = rt data, 1 = extended immediate
ALUOp  output  3  000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and, 101 slt (signed)
ExtSel  output  1  0 = zero-extend (ori), 1 = sign-extend
mRD  output  1  data memory read enable
mWR  output  1  data memory write enable
DBDataSrc  output  1  0 = ALU result, 1 = data memory output
RegDst  output  2  00 = $31, 01 = rt, 10 = rd
WrRegDSrc  output  1  0 = PC+4 (jal link), 1 = DB bus
PCSrc  output  2  00 = PC+4, 01 = PC+4+(sext imm<<2), 10 = rs, 11 = {PC+4[31:28], address, 2'b00}

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- States: IF 0000, ID 0001, EXE_AL 0010, WB_AL 0011, EXE_BR 0100, EXE_LS 0101, MEM 0110, WB_LD 0111, HALT 1000.
- The state register is the only sequential element. All other outputs are combinational from (state, op, zero).
- Transitions:
  - IF -> ID.
  - ID: j/jal/jr -> IF; halt -> HALT; beq -> EXE_BR; lw/sw -> EXE_LS; add/sub/addi/or/and/ori/sll/slt -> EXE_AL; any other op -> IF (nop; PCWre=1, PCSrc=00 in ID).
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM: sw -> IF; lw -> WB_LD.
  - WB_LD -> IF.
  - HALT -> HALT until Reset.
- IRWre=1 only in IF.
- PCWre=1 only in:
  - ID for j/jal/jr/unknown;
  - EXE_BR;
  - MEM for sw;
  - WB_AL;
  - WB_LD.
  - PC therefore advances exactly once per instruction, as the instruction's last cycle ends.
- PCSrc:
  - jr -> 10; j/jal -> 11;
  - beq -> 01 if zero, else 00;
  - all others -> 00.
  - Held for the whole instruction.
- RegWre=1 in WB_AL, WB_LD, and ID for jal (RegDst=00, WrRegDSrc=0). RegWre=0 everywhere else.
- ALUSrcA=1 only for sll.
- ALUSrcB=1 for addi/ori/lw/sw.
- ExtSel=0 only for ori.
- ALUOp by instruction:
  - add/addi/lw/sw -> 000;
  - sub/beq -> 001;
  - sll -> 010;
  - or/ori -> 011;
  - and -> 100;
  - slt -> 101.
  - Held constant from ID through the last cycle.
- mRD=1 in MEM and WB_LD for lw. mWR=1 only in MEM for sw.
- DBDataSrc=1 for lw, else 0.
- RegDst: 10 for R-type (add/sub/or/and/sll/slt), 01 for addi/ori/lw, 00 for jal.
- WrRegDSrc=1 except jal.
- HALT: PCWre=IRWre=RegWre=mWR=mRD=0; PC and register file frozen.
- Reset=1, in any state including mid-instruction or HALT:
  - all enable outputs (PCWre, IRWre, RegWre, mRD, mWR) forced 0 that cycle;
  - next state IF;
  - no partial writeback.
- After Reset deasserts, first cycle is IF with IRWre=1.
- All unlisted selects default 0 in every state.

Test Plan:
- Reset held 2 cycles then released, op=000010 (addi) -> states IF,ID,EXE_AL,WB_AL,IF. RegWre=1, RegDst=01, ALUSrcB=1, PCWre=1 only in WB_AL.
- op=110001 (lw) -> IF,ID,EXE_LS,MEM,WB_LD (5 cycles). mRD=1 in MEM/WB_LD, DBDataSrc=1, RegWre=1 only in WB_LD. Then op=110000 (sw) -> 4 cycles, mWR=1 only in MEM.
- op=110100 (beq) with zero=1 -> EXE_BR PCSrc=01, PCWre=1, ALUOp=001. Repeat with zero=0 -> PCSrc=00.
- op=111010 (jal) -> 2 cycles. In ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
- op=111111 (halt) -> HALT held 10 cycles with all enables 0. Reset=1 -> IF next edge.
- Reset asserted in MEM of sw -> mWR=0 that cycle, next state IF. Unknown op 101010 -> 2-cycle nop, RegWre never 1.
